// File: rtl/cdc_send_if.sv
// Source-side bundle of the toggle-handshake crossing.
// master: the sender (drives din_ready/xdata/xreq/busy); slave: producer + destination side.
interface cdc_send_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] xdata;
    logic             xreq;
    logic             xack;
    logic             busy;

    modport master (
        input  din, din_valid, xack,
        output din_ready, xdata, xreq, busy
    );

    modport slave (
        output din, din_valid, xack,
        input  din_ready, xdata, xreq, busy
    );
endinterface

// File: rtl/cdc_send.sv
// Sender half of a toggle-handshake CDC: words held on xdata, flagged by an xreq edge.
// Ports: clk, rst (async, active-high), bus (cdc_send_if.master: din/din_valid/din_ready, xdata/xreq/xack, busy).
module cdc_send #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    cdc_send_if.master  bus
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state, state_n;
    logic             xreq_q, xreq_n;
    logic [WIDTH-1:0] xdata_q, xdata_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             pend_valid, pend_valid_n;
    logic [STAGES-1:0] ack_sync;

    logic ack_s;
    logic done;
    logic ready;
    logic accept;

    assign ack_s  = ack_sync[STAGES-1];
    assign done   = (state == S_WAIT) && (ack_s == xreq_q);
    assign ready  = (state == S_IDLE) || !pend_valid;
    assign accept = bus.din_valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[STAGES-2:0], bus.xack};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            xreq_q     <= 1'b0;
            xdata_q    <= INIT;
            pend       <= INIT;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_n;
            xreq_q     <= xreq_n;
            xdata_q    <= xdata_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        xreq_n       = xreq_q;
        xdata_n      = xdata_q;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    xdata_n = bus.din;
                    xreq_n  = ~xreq_q;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    if (pend_valid) begin
                        // ready is low here, so no accept can collide
                        xdata_n      = pend;
                        xreq_n       = ~xreq_q;
                        pend_valid_n = 1'b0;
                    end else if (accept) begin
                        // bypass: launch the new word straight away
                        xdata_n = bus.din;
                        xreq_n  = ~xreq_q;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (accept) begin
                    pend_n       = bus.din;
                    pend_valid_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.din_ready = ready;
    assign bus.xdata     = xdata_q;
    assign bus.xreq      = xreq_q;
    assign bus.busy      = (state == S_WAIT) || pend_valid;

endmodule
